audio_session_ctrl: RTL

//  Top-level session sequencer for the WM8731 audio path.
//  - Brings up the codec over I2C with timeout and retry.
//  - Arms record, play or loopback sessions, aligned to the codec LRCK frame edge.
//  - Counts frames against a length limit and drives enables/start pulses to recorder, DSP and player.
//  - Supports pause/resume and per-channel DSP enables.

---
 rtl/audio_session_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/audio_session_ctrl.sv
// audio_session_ctrl: session sequencer for the WM8731 audio path.
//   Brings the codec up over I2C (timeout + retry), then arms record, play or
//   loopback sessions aligned to the codec LRCK frame edge, counts frames
//   against MAX_FRAMES, and drives recorder/player/DSP enables and start pulses.
// Optional feature macro: AUDIO_AUTO_LOOP_EN (play sessions restart on length limit).
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_key_start/stop/pause  1-cycle key pulses (priority stop > pause > start)
//   i_mode, i_ch_en     session mode and channel enables, latched at fresh start
//   i_i2c_fin           I2C initializer done
//   i_lrck              codec DACLRCK (asynchronous)
//   o_i2c_start         I2C initializer run request
//   o_rec_en, o_play_en, o_dsp_ch_en  enables, asserted only in S_RUN
//   o_dsp_start         1-cycle pulse at each fresh session start
//   o_frame_cnt         frames elapsed in current session
//   o_state             FSM state, o_err sticky init failure
module audio_session_ctrl #(
  parameter int unsigned NCH          = 2,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned MAX_FRAMES   = 1000,
  parameter int unsigned INIT_TIMEOUT = 50000,
  parameter int unsigned INIT_RETRIES = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_key_start,
  input  logic             i_key_stop,
  input  logic             i_key_pause,
  input  logic [1:0]       i_mode,
  input  logic [NCH-1:0]   i_ch_en,
  input  logic             i_i2c_fin,
  input  logic             i_lrck,
  output logic             o_i2c_start,
  output logic             o_rec_en,
  output logic             o_play_en,
  output logic             o_dsp_start,
  output logic [NCH-1:0]   o_dsp_ch_en,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [2:0]       o_state,
  output logic             o_err
);

  localparam int unsigned TMR_W = $clog2(INIT_TIMEOUT + 1);
  localparam int unsigned RTY_W = $clog2(INIT_RETRIES + 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [RTY_W-1:0] retry, retry_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [NCH-1:0]   ch_q, ch_nxt;
  logic             fresh, fresh_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             i2c_start_nxt;
  logic             dsp_start_nxt;
  logic             lrck_s1, lrck_s2, lrck_d;
  logic             lrck_edge;
  logic             run_nxt;

  // 2-FF synchronizer plus one delay stage for rising-edge detect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lrck_s1 <= 1'b0;
      lrck_s2 <= 1'b0;
      lrck_d  <= 1'b0;
    end else begin
      lrck_s1 <= i_lrck;
      lrck_s2 <= lrck_s1;
      lrck_d  <= lrck_s2;
    end
  end

  assign lrck_edge = lrck_s2 & ~lrck_d;

  // State and datapath registers; outputs registered from next-state values
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_INIT;
      timer       <= '0;
      retry       <= '0;
      mode_q      <= '0;
      ch_q        <= '0;
      fresh       <= 1'b0;
      o_frame_cnt <= '0;
      o_i2c_start <= 1'b1;
      o_dsp_start <= 1'b0;
      o_rec_en    <= 1'b0;
      o_play_en   <= 1'b0;
      o_dsp_ch_en <= '0;
      o_state     <= S_INIT;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      retry       <= retry_nxt;
      mode_q      <= mode_nxt;
      ch_q        <= ch_nxt;
      fresh       <= fresh_nxt;
      o_frame_cnt <= cnt_nxt;
      o_i2c_start <= i2c_start_nxt;
      o_dsp_start <= dsp_start_nxt;
      o_rec_en    <= run_nxt && ((mode_nxt == 2'b01) || (mode_nxt == 2'b10));
      o_play_en   <= run_nxt && (mode_nxt != 2'b01);
      o_dsp_ch_en <= run_nxt ? ch_nxt : '0;
      o_state     <= state_nxt;
      o_err       <= (state_nxt == S_ERR);
    end
  end

  assign run_nxt = (state_nxt == S_RUN);

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    retry_nxt     = retry;
    mode_nxt      = mode_q;
    ch_nxt        = ch_q;
    fresh_nxt     = fresh;
    cnt_nxt       = o_frame_cnt;
    i2c_start_nxt = 1'b0;
    dsp_start_nxt = 1'b0;

    case (state)
      S_INIT: begin
        if (i_i2c_fin) begin
          state_nxt = S_IDLE;
        end else if (timer == TMR_W'(INIT_TIMEOUT - 1)) begin
          // drop the request for one cycle to restart the initializer
          timer_nxt = '0;
          retry_nxt = retry + RTY_W'(1);
          if (retry + RTY_W'(1) == RTY_W'(INIT_RETRIES)) begin
            state_nxt = S_ERR;
          end
        end else begin
          timer_nxt     = timer + TMR_W'(1);
          i2c_start_nxt = 1'b1;
        end
      end

      S_IDLE: begin
        if (i_key_start && !i_key_stop && !i_key_pause) begin
          mode_nxt  = i_mode;
          ch_nxt    = i_ch_en;
          fresh_nxt = 1'b1;
          state_nxt = S_ARM;
        end
      end

      S_ARM: begin
        if (i_key_stop) begin
          state_nxt = S_IDLE;
        end else if (lrck_edge) begin
          state_nxt = S_RUN;
          if (fresh) begin
            dsp_start_nxt = 1'b1;
            cnt_nxt       = '0;
            fresh_nxt     = 1'b0;
          end
        end
      end

      S_RUN: begin
        // a coincident edge is counted before any key takes effect
        if (lrck_edge) begin
          if (o_frame_cnt == CNT_W'(MAX_FRAMES - 1)) begin
`ifdef AUDIO_AUTO_LOOP_EN
            if (mode_q == 2'b00 || mode_q == 2'b11) begin
              cnt_nxt       = '0;
              dsp_start_nxt = 1'b1;
            end else begin
              cnt_nxt   = CNT_W'(MAX_FRAMES);
              state_nxt = S_IDLE;
            end
`else
            cnt_nxt   = CNT_W'(MAX_FRAMES);
            state_nxt = S_IDLE;
`endif
          end else begin
            cnt_nxt = o_frame_cnt + CNT_W'(1);
          end
        end
        if (i_key_stop) begin
          state_nxt     = S_IDLE;
          dsp_start_nxt = 1'b0;
        end else if (i_key_pause && state_nxt == S_RUN) begin
          state_nxt     = S_PAUSE;
          dsp_start_nxt = 1'b0;
        end
      end

      S_PAUSE: begin
        if (i_key_stop) begin
          state_nxt = S_IDLE;
        end else if (i_key_pause || i_key_start) begin
          fresh_nxt = 1'b0;
          state_nxt = S_ARM;
        end
      end

      S_ERR: begin
        state_nxt = S_ERR;
      end

      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

endmodule
